// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder controller.
// Latches two DIGITS-wide BCD operands on start. It then adds one digit per cycle,
// least significant digit first, and ripples the decimal carry through a register.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   S,
    output logic                  Cout,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   a_q, a_d;
    logic [4*DIGITS-1:0]   b_q, b_d;
    logic                  carry_q, carry_d;
    logic [4*DIGITS-1:0]   s_q, s_d;
    logic                  cout_q, cout_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [3:0]            dig_a;
    logic [3:0]            dig_b;
    logic [4:0]            dig_sum;
    logic [3:0]            dig_out;
    logic                  dig_carry;
    logic                  bad_input;
    logic                  last_digit;

    // Select the current digit pair and apply the decimal correction to their sum.
    always_comb begin
        dig_a = 4'd0;
        dig_b = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                dig_a = a_q[4*i +: 4];
                dig_b = b_q[4*i +: 4];
            end
        end
        dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_q};
        if (dig_sum > 5'd9) begin
            dig_out   = 4'(dig_sum + 5'd6);
            dig_carry = 1'b1;
        end else begin
            dig_out   = dig_sum[3:0];
            dig_carry = 1'b0;
        end
        last_digit = (idx_q == IDXW'(DIGITS - 1));
    end

    // Flag any non-BCD nibble on the incoming operands. It is sampled only at accept.
    always_comb begin
        bad_input = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((A[4*i +: 4] > 4'd9) || (B[4*i +: 4] > 4'd9)) begin
                bad_input = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. Outputs are registered alongside the state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    s_d     = '0;
                    err_d   = bad_input;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        s_d[4*i +: 4] = dig_out;
                    end
                end
                carry_d = dig_carry;
                if (last_digit) begin
                    state_d = DONE;
                    cout_d  = dig_carry;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register. A synchronous reset overrides everything, including a running add.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard testbench for bcd_serial_add_ctrl.
// The driver pushes expected results into a queue.
// The monitor pops and compares one entry on every done pulse.
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;
    localparam int IDXW   = 4;
    localparam int W      = 4 * DIGITS;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          Cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  S;
    logic          Cout;
    logic          err;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         err;
        int           done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total_checks;
    int   fail_count;
    int   cyc;
    int   busy_cnt;

    bcd_serial_add_ctrl #(
        .DIGITS (DIGITS),
        .IDXW   (IDXW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .err   (err)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so that the monitor can measure latency.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point, used by both the driver and the monitor.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model. Valid operands use plain decimal arithmetic.
    // Operands with non-BCD digits use the per-digit +6 correction rule.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t   e;
        longint da, db, tot, modv, p;
        int     c, x, y, t, d;
        e.s    = '0;
        e.cout = 1'b0;
        e.err  = 1'b0;
        e.done_cyc = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (((a >> (4*i)) & 'hF) > 9 || ((b >> (4*i)) & 'hF) > 9) e.err = 1'b1;
        end
        if (!e.err) begin
            da = 0; db = 0; p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                da += longint'((a >> (4*i)) & 'hF) * p;
                db += longint'((b >> (4*i)) & 'hF) * p;
                p  *= 10;
            end
            modv   = p;
            tot    = da + db + longint'(cin);
            e.cout = (tot >= modv);
            tot    = tot % modv;
            for (int i = 0; i < DIGITS; i++) begin
                e.s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(cin);
            for (int i = 0; i < DIGITS; i++) begin
                x = int'((a >> (4*i)) & 'hF);
                y = int'((b >> (4*i)) & 'hF);
                t = x + y + c;
                if (t > 9) begin
                    d = (t + 6) % 16;
                    c = 1;
                end else begin
                    d = t;
                    c = 0;
                end
                e.s[4*i +: 4] = 4'(d);
            end
            e.cout = c[0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] randBcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad) v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Assert start for one cycle and queue the expected result.
    // Then scramble the inputs to show that the latched values are used.
    // Returns at the falling edge of the first RUN cycle.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        exp_t e;
        @(negedge clk);
        A     = a;
        B     = b;
        Cin   = cin;
        start = 1'b1;
        e = refModel(a, b, cin);
        e.done_cyc = cyc + 1 + DIGITS;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
        Cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: on every done pulse, compare against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sum",      64'(S),    64'(e.s));
                checkOutput("cout",     64'(Cout), 64'(e.cout));
                checkOutput("err",      64'(err),  64'(e.err));
                checkOutput("latency",  64'(cyc),  64'(e.done_cyc));
                checkOutput("busy_len", 64'(busy_cnt), 64'(DIGITS));
            end
            busy_cnt = 0;
        end else if (!busy) begin
            busy_cnt = 0;
        end
    end

    // Directed scenarios first, then randomized operations, then drain the scoreboard.
    initial begin
        exp_t dummy;
        int   guard;
        bit   b2b;
        total_checks = 0;
        fail_count   = 0;
        busy_cnt     = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        waitCycles(3);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_S",    64'(S),    64'd0);
        checkOutput("rst_cout", 64'(Cout), 64'd0);
        checkOutput("rst_err",  64'(err),  64'd0);
        rst = 1'b0;
        waitCycles(1);

        applyStimulus(16'h1234, 16'h5678, 1'b0);
        waitCycles(DIGITS + 2);
        applyStimulus(16'h9999, 16'h0001, 1'b0);
        waitCycles(DIGITS + 2);

        applyStimulus(16'h0005, 16'h0001, 1'b1);
        waitCycles(DIGITS - 1);
        applyStimulus(16'h0009, 16'h0009, 1'b0);
        waitCycles(DIGITS + 2);

        applyStimulus(16'h00A0, 16'h0001, 1'b0);
        waitCycles(DIGITS + 1);
        applyStimulus(16'h0001, 16'h0002, 1'b0);
        waitCycles(DIGITS + 1);

        applyStimulus(16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        A     = 16'h9999;
        B     = 16'h9999;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCycles(DIGITS + 1);

        applyStimulus(16'h4321, 16'h1234, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dummy = exp_q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_S",    64'(S),    64'd0);
        checkOutput("abort_cout", 64'(Cout), 64'd0);
        checkOutput("abort_err",  64'(err),  64'd0);
        waitCycles(DIGITS + 2);
        applyStimulus(16'h0042, 16'h0058, 1'b0);
        waitCycles(DIGITS + 1);

        for (int n = 0; n < 30; n++) begin
            b2b = ($urandom_range(0, 2) == 0);
            applyStimulus(randBcd($urandom_range(0, 5) == 0),
                          randBcd($urandom_range(0, 5) == 0),
                          1'($urandom_range(0, 1)));
            if (b2b) waitCycles(DIGITS - 1);
            else     waitCycles(DIGITS + 1 + $urandom_range(0, 2));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
        $finish;
    end

endmodule
